// File: rtl/shiftreg_pkg.sv
// Shared constants, state encoding and helpers for the shift-register sequencer.
package shiftreg_pkg;

  // Default frame geometry.
  localparam int unsigned DefSizeSrStat = 88;
  localparam int unsigned DefSizeSrDyn  = 16;
  localparam int unsigned DefGapCycles  = 2;

  // Width of the bit counter; covers phases of up to 128 bits and the gap count.
  localparam int unsigned BitCntW = 7;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StStat = 3'd2,
    StGap  = 3'd3,
    StDyn  = 3'd4,
    StFin  = 3'd5
  } state_e;

  // Index width needed to address an n-bit shadow word (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shiftreg_sequencer_if.sv
// Request/response bundle between a frame requester and the sequencer.
interface shiftreg_sequencer_if #(
  parameter int unsigned SIZESRSTAT = shiftreg_pkg::DefSizeSrStat,
  parameter int unsigned SIZESRDYN  = shiftreg_pkg::DefSizeSrDyn
);
  import shiftreg_pkg::*;

  // Requester side
  logic                  START;
  logic                  ABORT;
  logic [SIZESRSTAT-1:0] STAT_WORD;
  logic [SIZESRDYN-1:0]  DYN_WORD;

  // Sequencer side
  logic                  SELSTAT;
  logic                  SELDYN;
  logic                  SDATA;
  logic [BitCntW-1:0]    BIT_CNT;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output START,
    output ABORT,
    output STAT_WORD,
    output DYN_WORD,
    input  SELSTAT,
    input  SELDYN,
    input  SDATA,
    input  BIT_CNT,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  START,
    input  ABORT,
    input  STAT_WORD,
    input  DYN_WORD,
    output SELSTAT,
    output SELDYN,
    output SDATA,
    output BIT_CNT,
    output BUSY,
    output DONE
  );

endinterface

// File: rtl/shiftreg_sequencer_phase_counter.sv
// Phase counter: clears on load, counts up while enabled, flags the terminal value.
module phase_counter #(
  parameter int unsigned Width = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [Width-1:0] i_last,
  output logic [Width-1:0] o_cnt,
  output logic             o_tc
);

  logic [Width-1:0] r_cnt_q;
  logic [Width-1:0] w_cnt_d;

  // Next count: load wins over enable so every phase starts from zero.
  always_comb begin
    w_cnt_d = r_cnt_q;
    if (i_load) begin
      w_cnt_d = '0;
    end else if (i_en) begin
      w_cnt_d = r_cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_q <= '0;
    end else begin
      r_cnt_q <= w_cnt_d;
    end
  end

  assign o_cnt = r_cnt_q;
  assign o_tc  = (r_cnt_q == i_last);

endmodule

// File: rtl/shiftreg_sequencer.sv
// Frame sequencer: serialises a static word then a dynamic word, MSB first,
// with a programmable idle gap between the two phases. All outputs are
// registered one cycle behind the state register.
module shiftreg_sequencer
  import shiftreg_pkg::*;
#(
  parameter int unsigned SIZESRSTAT = DefSizeSrStat,
  parameter int unsigned SIZESRDYN  = DefSizeSrDyn,
  parameter int unsigned GAP_CYCLES = DefGapCycles
) (
  input logic                 CLK,
  input logic                 RST_N,
  shiftreg_sequencer_if.slave bus
);

  localparam int unsigned StatIdxW = idx_w(SIZESRSTAT);
  localparam int unsigned DynIdxW  = idx_w(SIZESRDYN);

  // Terminal counts per counted state.
  localparam logic [BitCntW-1:0] LastStat = BitCntW'(SIZESRSTAT - 1);
  localparam logic [BitCntW-1:0] LastDyn  = BitCntW'(SIZESRDYN - 1);
  localparam logic [BitCntW-1:0] LastGap  = BitCntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e r_state_q;
  state_e w_state_d;

  logic [SIZESRSTAT-1:0] r_stat_q;
  logic [SIZESRDYN-1:0]  r_dyn_q;

  logic               w_accept;
  logic               w_abort;
  logic               w_cnt_load;
  logic               w_cnt_en;
  logic [BitCntW-1:0] w_cnt;
  logic [BitCntW-1:0] w_last;
  logic               w_tc;

  logic [StatIdxW-1:0] w_stat_idx;
  logic [DynIdxW-1:0]  w_dyn_idx;
  logic                w_sdata;
  logic [BitCntW-1:0]  w_bit_cnt;

  logic               r_selstat_q;
  logic               r_seldyn_q;
  logic               r_sdata_q;
  logic [BitCntW-1:0] r_bit_cnt_q;
  logic               r_busy_q;
  logic               r_done_q;

  // ABORT beats START in IDLE; outside IDLE START is simply not looked at.
  assign w_accept = (r_state_q == StIdle) && bus.START && !bus.ABORT;
  assign w_abort  = (r_state_q != StIdle) && bus.ABORT;

  // Next-state logic and per-state terminal count selection.
  always_comb begin
    w_state_d = r_state_q;
    w_last    = '0;
    unique case (r_state_q)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_state_d = StStat;
      end
      StStat: begin
        w_last = LastStat;
        if (w_tc) begin
          w_state_d = (GAP_CYCLES == 0) ? StDyn : StGap;
        end
      end
      StGap: begin
        w_last = LastGap;
        if (w_tc) begin
          w_state_d = StDyn;
        end
      end
      StDyn: begin
        w_last = LastDyn;
        if (w_tc) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    if (w_abort) begin
      w_state_d = StIdle;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state_q <= StIdle;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  // Shadow words are only written on an accepted START, so they hold while busy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stat_q <= '0;
      r_dyn_q  <= '0;
    end else if (w_accept) begin
      r_stat_q <= bus.STAT_WORD;
      r_dyn_q  <= bus.DYN_WORD;
    end
  end

  // Counter restarts on every state change and only runs in counted states.
  assign w_cnt_load = (w_state_d != r_state_q);
  assign w_cnt_en   = (r_state_q == StStat) || (r_state_q == StGap) || (r_state_q == StDyn);

  phase_counter #(
    .Width (BitCntW)
  ) u_phase_counter (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_load  (w_cnt_load),
    .i_en    (w_cnt_en),
    .i_last  (w_last),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // MSB-first bit selection.
  assign w_stat_idx = StatIdxW'(SIZESRSTAT - 1) - w_cnt[StatIdxW-1:0];
  assign w_dyn_idx  = DynIdxW'(SIZESRDYN - 1) - w_cnt[DynIdxW-1:0];

  // Serial data and bit index are only meaningful in the shift phases.
  always_comb begin
    w_sdata   = 1'b0;
    w_bit_cnt = '0;
    unique case (r_state_q)
      StStat: begin
        w_sdata   = r_stat_q[w_stat_idx];
        w_bit_cnt = w_cnt;
      end
      StDyn: begin
        w_sdata   = r_dyn_q[w_dyn_idx];
        w_bit_cnt = w_cnt;
      end
      default: begin
        w_sdata   = 1'b0;
        w_bit_cnt = '0;
      end
    endcase
  end

  // Output registers; an abort clears them on the same edge the FSM returns to IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_selstat_q <= 1'b0;
      r_seldyn_q  <= 1'b0;
      r_sdata_q   <= 1'b0;
      r_bit_cnt_q <= '0;
      r_busy_q    <= 1'b0;
      r_done_q    <= 1'b0;
    end else if (w_abort) begin
      r_selstat_q <= 1'b0;
      r_seldyn_q  <= 1'b0;
      r_sdata_q   <= 1'b0;
      r_bit_cnt_q <= '0;
      r_busy_q    <= 1'b0;
      r_done_q    <= 1'b0;
    end else begin
      r_selstat_q <= (r_state_q == StStat);
      r_seldyn_q  <= (r_state_q == StDyn);
      r_sdata_q   <= w_sdata;
      r_bit_cnt_q <= w_bit_cnt;
      r_busy_q    <= (r_state_q != StIdle);
      r_done_q    <= (r_state_q == StFin);
    end
  end

  assign bus.SELSTAT = r_selstat_q;
  assign bus.SELDYN  = r_seldyn_q;
  assign bus.SDATA   = r_sdata_q;
  assign bus.BIT_CNT = r_bit_cnt_q;
  assign bus.BUSY    = r_busy_q;
  assign bus.DONE    = r_done_q;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Directed bench for shiftreg_sequencer: a GAP_CYCLES=2 instance for frame,
// abort, re-start and reset cases, and a GAP_CYCLES=0 instance for back-to-back frames.
module tb_shiftreg_sequencer;
  import shiftreg_pkg::*;

  localparam int unsigned SS = 88;
  localparam int unsigned SD = 16;

  localparam logic [SS-1:0] StatA = 88'h123456789ABCDEF1234567;
  localparam logic [SD-1:0] DynA  = 16'hABCD;
  localparam logic [SS-1:0] StatB = 88'hF0E1D2C3B4A5968778695A;
  localparam logic [SD-1:0] DynB  = 16'h1234;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  shiftreg_sequencer_if #(.SIZESRSTAT(SS), .SIZESRDYN(SD)) bus  ();
  shiftreg_sequencer_if #(.SIZESRSTAT(SS), .SIZESRDYN(SD)) bus0 ();

  shiftreg_sequencer #(
    .SIZESRSTAT (SS),
    .SIZESRDYN  (SD),
    .GAP_CYCLES (2)
  ) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  shiftreg_sequencer #(
    .SIZESRSTAT (SS),
    .SIZESRDYN  (SD),
    .GAP_CYCLES (0)
  ) u_dut0 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All outputs of the main instance packed: {SELSTAT,SELDYN,SDATA,DONE,BUSY,BIT_CNT}.
  function automatic logic [11:0] outs();
    return {bus.SELSTAT, bus.SELDYN, bus.SDATA, bus.DONE, bus.BUSY, bus.BIT_CNT};
  endfunction

  // Called at a negedge; returns at the negedge right after the edge that sampled START.
  task automatic pulse_start(input logic [SS-1:0] s, input logic [SD-1:0] d);
    bus.STAT_WORD = s;
    bus.DYN_WORD  = d;
    bus.START     = 1'b1;
    @(negedge CLK);
    bus.START     = 1'b0;
  endtask

  // Follows a whole frame right after pulse_start; optionally re-pulses START in DYN.
  task automatic frame_check(input string tag, input logic [SS-1:0] s, input logic [SD-1:0] d,
                             input bit repulse);
    logic [SS-1:0] ser_s;
    logic [SD-1:0] ser_d;
    bit ok;
    @(negedge CLK);
    check({tag, "_busy_rise"}, {bus.BUSY, bus.SELSTAT}, 2'b10);
    ok    = 1'b1;
    ser_s = '0;
    for (int i = 0; i < int'(SS); i++) begin
      @(negedge CLK);
      ser_s = {ser_s[SS-2:0], bus.SDATA};
      if (!(bus.SELSTAT && !bus.SELDYN && bus.BUSY && bus.BIT_CNT == 7'(i))) ok = 1'b0;
    end
    check({tag, "_stat_data"}, ser_s, s);
    check({tag, "_stat_ctl"}, ok, 1'b1);
    for (int g = 0; g < 2; g++) begin
      @(negedge CLK);
      check({tag, "_gap"}, outs(), 12'b00001_0000000);
    end
    ok    = 1'b1;
    ser_d = '0;
    for (int i = 0; i < int'(SD); i++) begin
      @(negedge CLK);
      ser_d = {ser_d[SD-2:0], bus.SDATA};
      if (!(bus.SELDYN && !bus.SELSTAT && bus.BUSY && bus.BIT_CNT == 7'(i))) ok = 1'b0;
      if (repulse && i == 4) begin
        bus.STAT_WORD = ~s;
        bus.DYN_WORD  = ~d;
        bus.START     = 1'b1;
      end
      if (i == 5) bus.START = 1'b0;
    end
    check({tag, "_dyn_data"}, ser_d, d);
    check({tag, "_dyn_ctl"}, ok, 1'b1);
    @(negedge CLK);
    check({tag, "_done"}, {bus.DONE, bus.BUSY, bus.SELDYN, bus.SELSTAT}, 4'b1100);
    @(negedge CLK);
    check({tag, "_idle"}, {bus.DONE, bus.BUSY}, 2'b00);
    if (repulse) begin
      ok = 1'b1;
      repeat (5) begin
        @(negedge CLK);
        if (bus.BUSY || bus.SELSTAT) ok = 1'b0;
      end
      check({tag, "_not_queued"}, ok, 1'b1);
    end
  endtask

  initial begin
    bit ok;
    bit seen;
    bit prev_sel;
    int n_done;
    int first_done;
    int last_done;
    int n_handoff;
    bit excl_ok;
    bit nogap_ok;
    bit period_ok;

    bus.START      = 1'b0;
    bus.ABORT      = 1'b0;
    bus.STAT_WORD  = '0;
    bus.DYN_WORD   = '0;
    bus0.START     = 1'b0;
    bus0.ABORT     = 1'b0;
    bus0.STAT_WORD = StatA;
    bus0.DYN_WORD  = DynA;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outs", outs(), 12'h000);
    check("reset_outs_gap0", {bus0.SELSTAT, bus0.SELDYN, bus0.BUSY, bus0.DONE}, 4'b0000);

    // Nominal frame, START presented on the first edge after reset release
    RST_N = 1'b1;
    pulse_start(StatA, DynA);
    frame_check("frame1", StatA, DynA, 1'b0);

    // Abort at static bit 40
    pulse_start(StatB, DynB);
    repeat (42) @(negedge CLK);
    check("abort_at40", {bus.SELSTAT, bus.BIT_CNT}, {1'b1, 7'd40});
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    check("abort_drop", {bus.SELSTAT, bus.SELDYN, bus.BUSY, bus.DONE}, 4'b0000);
    seen = 1'b0;
    repeat (120) begin
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);

    // Normal frame after abort
    pulse_start(StatB, DynB);
    frame_check("post_abort", StatB, DynB, 1'b0);

    // START re-pulsed with other words during DYN
    pulse_start(StatA, DynA);
    frame_check("repulse", StatA, DynA, 1'b1);

    // Asynchronous reset mid-DYN
    pulse_start(StatB, DynB);
    repeat (95) @(negedge CLK);
    check("rst_pre_dyn", {bus.SELDYN, bus.BIT_CNT}, {1'b1, 7'd3});
    #2 RST_N = 1'b0;
    #1 check("rst_async_outs", outs(), 12'h000);
    @(negedge CLK);
    RST_N = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    check("rst_no_done", seen, 1'b0);

    // START and ABORT together in IDLE
    bus.STAT_WORD = StatA;
    bus.DYN_WORD  = DynA;
    bus.START     = 1'b1;
    bus.ABORT     = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (bus.BUSY || bus.SELSTAT || bus.SELDYN) ok = 1'b0;
    end
    check("start_abort_idle", ok, 1'b1);

    // GAP_CYCLES=0, START held for 250 cycles
    bus0.START = 1'b1;
    prev_sel   = 1'b0;
    n_done     = 0;
    first_done = -1;
    last_done  = -1;
    n_handoff  = 0;
    excl_ok    = 1'b1;
    nogap_ok   = 1'b1;
    period_ok  = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge CLK);
      if (bus0.SELSTAT && bus0.SELDYN) excl_ok = 1'b0;
      if (prev_sel && !bus0.SELSTAT) begin
        n_handoff++;
        if (!bus0.SELDYN) nogap_ok = 1'b0;
      end
      if (bus0.DONE) begin
        if (n_done == 0) first_done = i;
        else if (i - last_done != 107) period_ok = 1'b0;
        last_done = i;
        n_done++;
      end
      prev_sel = bus0.SELSTAT;
    end
    bus0.START = 1'b0;
    check("gap0_exclusive", excl_ok, 1'b1);
    check("gap0_no_gap", nogap_ok, 1'b1);
    check("gap0_handoffs", n_handoff, 2);
    check("gap0_done_count", n_done, 2);
    check("gap0_first_done", first_done, 106);
    check("gap0_period", {period_ok, 32'(last_done)}, {1'b1, 32'd213});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
